multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle MIPS datapath: it sequences instruction fetch, decode, execute, memory and writeback over several cycles. One shared ALU is reused for PC increment, branch target, address and result computation. The block drives the 3-bit `alu_op` consumed by `alu_control`; `111` selects funct decoding, and any other value passes straight through as the ALU control code. It sits between the instruction register (opcode source), a handshaked unified memory, and the datapath muxes and write enables.

## Interface
- `FETCH_WAIT_MAX`, 0: reserved, must stay 0; no timeout, memory waits are unbounded.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  6  IR[31:26]; stable from the cycle after `ir_write` until the next fetch.
- `mem_ready`  in  1  memory completes the current `mem_read`/`mem_write` this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `reg_write`, `mem_read`, `mem_write`  out  1 each  datapath strobes.
- `i_or_d`  out  1  0 = PC addresses memory, 1 = ALUOut.
- `mem_to_reg`  out  1  1 = MDR to register file.
- `reg_dst`  out  1  1 = rd, 0 = rt.
- `alu_src_a`  out  1  0 = PC, 1 = A.
- `alu_src_b`  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `alu_op`  out  3  101 add, 110 sub, 000 and, 001 or, 100 slt, 111 R-type.
- `pc_source`  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- `state`  out  4  current state encoding.
- `instr_done`  out  1  one-cycle pulse on the final cycle of each instruction.
- `illegal_op`  out  1  one-cycle pulse in DECODE for an unsupported opcode.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPE_EX=6, ALU_WB=7, BEQ=8, JUMP=9, IMM_EX=10, IMM_WB=11. Encodings 12–15 are unreachable and go to FETCH.
- Outputs are Moore functions of `state`, except the `mem_ready`-gated strobes called out below. Every output not listed for a state is 0.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=101, `pc_source`=00.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE on `mem_ready`=1.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=101. Next state by opcode:
  - 000000 → RTYPE_EX
  - 100011 (lw) and 101011 (sw) → MEMADR
  - 000100 (beq) → BEQ
  - 000010 (j) → JUMP
  - 001000 addi, 001100 andi, 001101 ori, 001010 slti → IMM_EX
  - anything else → FETCH with `illegal_op`=1
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=101. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_read`=1, `i_or_d`=1. Waits for `mem_ready`, then MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1 → FETCH.
- MEMWR: `mem_write`=1, `i_or_d`=1. Waits for `mem_ready`; `instr_done`=`mem_ready`; then FETCH.
- RTYPE_EX: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=111 → ALU_WB.
- ALU_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1 → FETCH.
- BEQ: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=110, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1 → FETCH.
- JUMP: `pc_write`=1, `pc_source`=10, `instr_done`=1 → FETCH.
- IMM_EX: `alu_src_a`=1, `alu_src_b`=10; `alu_op` is 101/000/001/100 for addi/andi/ori/slti → IMM_WB.
- IMM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1 → FETCH.

## Timing
- Reset: while `reset`=1, `pc_write`, `pc_write_cond`, `ir_write`, `reg_write`, `mem_write`, `instr_done` and `illegal_op` are forced to 0 combinationally. The first edge with `reset`=1 sets `state`=0.
- Reset mid-instruction, including during a memory wait, abandons the instruction with no write strobe issued.
- After reset is released, FETCH outputs (`mem_read`=1, `alu_op`=101) are present immediately.
- Latency with zero memory wait, in cycles:
  - R-type 4, lw 5, sw 4, beq 3, j 3, immediate 4, illegal 2.
  - Each cycle `mem_ready` is held low adds exactly one cycle, in FETCH, MEMRD or MEMWR.
- `mem_ready` is ignored in states that do not request memory.
- `mem_read`/`mem_write` hold steady until the accepting cycle.

## Test plan
- Reset held 3 cycles, then released with `mem_ready`=1, opcode=000000 → `state` sequence 0,1,6,7,0; `alu_op` 101,101,111,xx; `reg_write`=1 and `reg_dst`=1 only in state 7; `instr_done` pulses once.
- lw (100011) with `mem_ready` low for 2 cycles in FETCH and 1 cycle in MEMRD → 8 cycles total; `ir_write` high exactly once; MEMWB asserts `mem_to_reg`=1 and `reg_dst`=0.
- sw (101011), then beq (000100), then j (000010), all with `mem_ready`=1 → 4, 3 and 3 cycles. BEQ shows `alu_op`=110, `pc_write_cond`=1, `pc_source`=01; JUMP shows `pc_write`=1, `pc_source`=10.
- addi/andi/ori/slti → IMM_EX `alu_op` = 101/000/001/100 respectively; IMM_WB `reg_write`=1, `reg_dst`=0.
- Opcode 111111 → `illegal_op`=1 for one cycle in DECODE, then back to FETCH, with no `reg_write`/`mem_write` at any point.
- `reset` asserted in MEMWR while `mem_ready`=0 → `mem_write` drops in the same cycle; the next edge gives `state`=0; no `instr_done` is issued.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode, execute,
// memory and writeback, driving mux selects, ALU op and write strobes from the current state.
module multicycle_control #(
    parameter int FETCH_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        ALU_WB   = 4'd7,
        BEQ      = 4'd8,
        JUMP     = 4'd9,
        IMM_EX   = 4'd10,
        IMM_WB   = 4'd11
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    if (FETCH_WAIT_MAX != 0) begin : gReservedParam
        $error("FETCH_WAIT_MAX is reserved and must be 0");
    end

    stateT curState;
    stateT nextState;
    logic  pcWriteRaw, pcWriteCondRaw, irWriteRaw, regWriteRaw, memWriteRaw;
    logic  instrDoneRaw, illegalOpRaw;

    function automatic logic [2:0] immAluOp(input logic [5:0] op);
        case (op)
            OP_ANDI: immAluOp = 3'b000;
            OP_ORI:  immAluOp = 3'b001;
            OP_SLTI: immAluOp = 3'b100;
            default: immAluOp = 3'b101;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) curState <= FETCH;
        else       curState <= nextState;
    end

    always_comb begin
        nextState = FETCH;
        case (curState)
            FETCH:    nextState = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:                         nextState = RTYPE_EX;
                    OP_LW, OP_SW:                     nextState = MEMADR;
                    OP_BEQ:                           nextState = BEQ;
                    OP_J:                             nextState = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nextState = IMM_EX;
                    default:                          nextState = FETCH;
                endcase
            end
            MEMADR:   nextState = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    nextState = mem_ready ? MEMWB : MEMRD;
            MEMWR:    nextState = mem_ready ? FETCH : MEMWR;
            RTYPE_EX: nextState = ALU_WB;
            IMM_EX:   nextState = IMM_WB;
            default:  nextState = FETCH;
        endcase
    end

    // Moore decode of the current state; only the memory-accept strobes look at mem_ready
    always_comb begin
        pcWriteRaw     = 1'b0;
        pcWriteCondRaw = 1'b0;
        irWriteRaw     = 1'b0;
        regWriteRaw    = 1'b0;
        memWriteRaw    = 1'b0;
        instrDoneRaw   = 1'b0;
        illegalOpRaw   = 1'b0;
        mem_read       = 1'b0;
        i_or_d         = 1'b0;
        mem_to_reg     = 1'b0;
        reg_dst        = 1'b0;
        alu_src_a      = 1'b0;
        alu_src_b      = 2'b00;
        alu_op         = 3'b000;
        pc_source      = 2'b00;
        case (curState)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                alu_op     = 3'b101;
                irWriteRaw = mem_ready;
                pcWriteRaw = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 3'b101;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: illegalOpRaw = 1'b0;
                    default:                           illegalOpRaw = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b101;
            end
            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEMWB: begin
                regWriteRaw  = 1'b1;
                mem_to_reg   = 1'b1;
                instrDoneRaw = 1'b1;
            end
            MEMWR: begin
                memWriteRaw  = 1'b1;
                i_or_d       = 1'b1;
                instrDoneRaw = mem_ready;
            end
            RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b111;
            end
            ALU_WB: begin
                regWriteRaw  = 1'b1;
                reg_dst      = 1'b1;
                instrDoneRaw = 1'b1;
            end
            BEQ: begin
                alu_src_a      = 1'b1;
                alu_op         = 3'b110;
                pcWriteCondRaw = 1'b1;
                pc_source      = 2'b01;
                instrDoneRaw   = 1'b1;
            end
            JUMP: begin
                pcWriteRaw   = 1'b1;
                pc_source    = 2'b10;
                instrDoneRaw = 1'b1;
            end
            IMM_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = immAluOp(opcode);
            end
            IMM_WB: begin
                regWriteRaw  = 1'b1;
                instrDoneRaw = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset suppresses every write strobe immediately so an abandoned instruction commits nothing
    assign pc_write      = pcWriteRaw     & ~reset;
    assign pc_write_cond = pcWriteCondRaw & ~reset;
    assign ir_write      = irWriteRaw     & ~reset;
    assign reg_write     = regWriteRaw    & ~reset;
    assign mem_write     = memWriteRaw    & ~reset;
    assign instr_done    = instrDoneRaw   & ~reset;
    assign illegal_op    = illegalOpRaw   & ~reset;
    assign state         = curState;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction state paths and outputs are derived from the
// instruction-class rules, with randomized memory waits and random mem_ready where it is ignored.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write;
    logic       i_or_d, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       instr_done, illegal_op;

    int nCmp  = 0;
    int nFail = 0;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4, S_MEMWR = 5;
    localparam int S_RTYPE = 6, S_ALUWB = 7, S_BEQ = 8, S_JUMP = 9, S_IMMEX = 10, S_IMMWB = 11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    always #5 clk = ~clk;

    multicycle_control #(.FETCH_WAIT_MAX(0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    // 0 R-type, 1 lw, 2 sw, 3 beq, 4 j, 5 immediate, 6 illegal
    function automatic int opClass(input logic [5:0] op);
        if (op == OP_R) return 0;
        if (op == OP_LW) return 1;
        if (op == OP_SW) return 2;
        if (op == OP_BEQ) return 3;
        if (op == OP_J) return 4;
        if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI || op == OP_SLTI) return 5;
        return 6;
    endfunction

    function automatic int baseLatency(input int cls);
        int lat [7] = '{4, 5, 4, 3, 3, 4, 2};
        return lat[cls];
    endfunction

    function automatic logic [18:0] obsWord();
        return {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, i_or_d,
                mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op};
    endfunction

    function automatic logic [18:0] expWord(input int st, input logic [5:0] op, input logic mr);
        logic       pcW = 0, pcWc = 0, irW = 0, regW = 0, memR = 0, memW = 0, iod = 0;
        logic       m2r = 0, rdst = 0, srcA = 0, done = 0, ill = 0;
        logic [1:0] srcB = 0, pcs = 0;
        logic [2:0] aop = 0;
        case (st)
            S_FETCH:  begin memR = 1; srcB = 2'b01; aop = 3'b101; irW = mr; pcW = mr; end
            S_DECODE: begin srcB = 2'b11; aop = 3'b101; ill = (opClass(op) == 6); end
            S_MEMADR: begin srcA = 1; srcB = 2'b10; aop = 3'b101; end
            S_MEMRD:  begin memR = 1; iod = 1; end
            S_MEMWB:  begin regW = 1; m2r = 1; done = 1; end
            S_MEMWR:  begin memW = 1; iod = 1; done = mr; end
            S_RTYPE:  begin srcA = 1; aop = 3'b111; end
            S_ALUWB:  begin regW = 1; rdst = 1; done = 1; end
            S_BEQ:    begin srcA = 1; aop = 3'b110; pcWc = 1; pcs = 2'b01; done = 1; end
            S_JUMP:   begin pcW = 1; pcs = 2'b10; done = 1; end
            S_IMMEX: begin
                srcA = 1; srcB = 2'b10;
                aop = (op == OP_ANDI) ? 3'b000 : (op == OP_ORI) ? 3'b001 :
                      (op == OP_SLTI) ? 3'b100 : 3'b101;
            end
            S_IMMWB:  begin regW = 1; done = 1; end
            default: ;
        endcase
        return {pcW, pcWc, irW, regW, memR, memW, iod, m2r, rdst, srcA, srcB, aop, pcs, done, ill};
    endfunction

    // Runs one instruction from its first FETCH cycle; fw/mw are mem_ready-low cycles in FETCH and MEMRD/MEMWR.
    task automatic runInstr(input logic [5:0] op, input int fw, input int mw, input string name,
                            output int irCnt, output int doneCnt, output int illCnt,
                            output int rwCnt, output int mwCnt, output int obsLat);
        int seq[$];
        int cls = opClass(op);
        irCnt = 0; doneCnt = 0; illCnt = 0; rwCnt = 0; mwCnt = 0; obsLat = 0;
        repeat (fw + 1) seq.push_back(S_FETCH);
        seq.push_back(S_DECODE);
        case (cls)
            0: begin seq.push_back(S_RTYPE); seq.push_back(S_ALUWB); end
            1: begin seq.push_back(S_MEMADR); repeat (mw + 1) seq.push_back(S_MEMRD); seq.push_back(S_MEMWB); end
            2: begin seq.push_back(S_MEMADR); repeat (mw + 1) seq.push_back(S_MEMWR); end
            3: seq.push_back(S_BEQ);
            4: seq.push_back(S_JUMP);
            5: begin seq.push_back(S_IMMEX); seq.push_back(S_IMMWB); end
            default: ;
        endcase
        for (int c = 0; c < seq.size(); c++) begin
            int  es = seq[c];
            bit  waitSt = (es == S_FETCH || es == S_MEMRD || es == S_MEMWR);
            bit  last = 1'b1;
            logic [18:0] ew;
            if (c + 1 < seq.size()) last = (seq[c + 1] != es);
            @(negedge clk);
            mem_ready = waitSt ? last : 1'($urandom);
            opcode    = (es == S_FETCH) ? 6'($urandom) : op;
            #1;
            ew = expWord(es, op, mem_ready);
            nCmp++;
            if (state !== 4'(es)) begin
                nFail++;
                $display("FAIL %s state cycle %0d: got %0d want %0d", name, c, state, es);
            end
            nCmp++;
            if (obsWord() !== ew) begin
                nFail++;
                $display("FAIL %s outputs cycle %0d: got %b want %b", name, c, obsWord(), ew);
            end
            irCnt   += int'(ir_write === 1'b1);
            doneCnt += int'(instr_done === 1'b1);
            illCnt  += int'(illegal_op === 1'b1);
            rwCnt   += int'(reg_write === 1'b1);
            mwCnt   += int'(mem_write === 1'b1);
            if (obsLat == 0 && (instr_done === 1'b1 || illegal_op === 1'b1)) obsLat = c + 1;
        end
        nCmp++;
        if (obsLat != baseLatency(cls) + fw + mw) begin
            nFail++;
            $display("FAIL %s latency: got %0d want %0d", name, obsLat, baseLatency(cls) + fw + mw);
        end
    endtask

    task automatic test_reset();
        logic [6:0] forced;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            opcode    = 6'($urandom);
            #1;
            forced = {pc_write, pc_write_cond, ir_write, reg_write, mem_write, instr_done, illegal_op};
            nCmp++;
            if (forced !== 7'b0) begin
                nFail++;
                $display("FAIL reset strobes cycle %0d: got %b want 0000000", c, forced);
            end
            nCmp++;
            if (state !== 4'd0) begin
                nFail++;
                $display("FAIL reset state cycle %0d: got %0d want 0", c, state);
            end
        end
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        nCmp++;
        if ({mem_read, alu_op, ir_write} !== {1'b1, 3'b101, 1'b0}) begin
            nFail++;
            $display("FAIL release fetch: mem_read=%b alu_op=%b ir_write=%b want 1 101 0",
                     mem_read, alu_op, ir_write);
        end
    endtask

    task automatic test_rtype();
        int ir, dn, il, rw, mw, lat;
        runInstr(OP_R, 0, 0, "rtype", ir, dn, il, rw, mw, lat);
        nCmp++;
        if (dn != 1 || rw != 1) begin
            nFail++;
            $display("FAIL rtype pulses: instr_done=%0d reg_write=%0d want 1 1", dn, rw);
        end
    endtask

    task automatic test_lw_wait();
        int ir, dn, il, rw, mw, lat;
        runInstr(OP_LW, 2, 1, "lw_wait", ir, dn, il, rw, mw, lat);
        nCmp++;
        if (ir != 1) begin
            nFail++;
            $display("FAIL lw_wait ir_write count: got %0d want 1", ir);
        end
    endtask

    task automatic test_back_to_back();
        int ir, dn, il, rw, mw, lat;
        runInstr(OP_SW, 0, 0, "sw", ir, dn, il, rw, mw, lat);
        nCmp++;
        if (mw != 1 || rw != 0) begin
            nFail++;
            $display("FAIL sw strobes: mem_write=%0d reg_write=%0d want 1 0", mw, rw);
        end
        runInstr(OP_BEQ, 0, 0, "beq", ir, dn, il, rw, mw, lat);
        runInstr(OP_J, 0, 0, "j", ir, dn, il, rw, mw, lat);
    endtask

    task automatic test_imm();
        logic [5:0] ops [4] = '{OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
        int ir, dn, il, rw, mw, lat;
        foreach (ops[i]) runInstr(ops[i], 0, 0, "imm", ir, dn, il, rw, mw, lat);
    endtask

    task automatic test_illegal();
        int ir, dn, il, rw, mw, lat;
        logic [5:0] op = 6'b111111;
        for (int k = 0; k < 3; k++) begin
            runInstr(op, k, 0, "illegal", ir, dn, il, rw, mw, lat);
            nCmp++;
            if (il != 1 || rw != 0 || mw != 0 || dn != 0) begin
                nFail++;
                $display("FAIL illegal pulses: illegal_op=%0d reg_write=%0d mem_write=%0d instr_done=%0d want 1 0 0 0",
                         il, rw, mw, dn);
            end
            do op = 6'($urandom); while (opClass(op) != 6);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [9] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
        int ir, dn, il, rw, mw, lat;
        for (int k = 0; k < 40; k++) begin
            logic [5:0] op = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            int cls = opClass(op);
            int memWait = (cls == 1 || cls == 2) ? int'($urandom_range(0, 2)) : 0;
            runInstr(op, $urandom_range(0, 3), memWait, "random", ir, dn, il, rw, mw, lat);
        end
    endtask

    // Reset while parked in a memory wait state; the instruction must leave no trace.
    task automatic test_reset_mid();
        logic [5:0] ops [2] = '{OP_LW, OP_SW};
        foreach (ops[i]) begin
            int waitSt = (ops[i] == OP_SW) ? S_MEMWR : S_MEMRD;
            int dn = 0, wr = 0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                mem_ready = (c == 0) ? 1'b1 : (c >= 3) ? 1'b0 : 1'($urandom);
                opcode    = (c == 0) ? 6'($urandom) : ops[i];
                #1;
                dn += int'(instr_done === 1'b1);
                wr += int'(reg_write === 1'b1);
            end
            nCmp++;
            if (state !== 4'(waitSt) || (ops[i] == OP_SW && mem_write !== 1'b1)) begin
                nFail++;
                $display("FAIL reset_mid pre: state=%0d mem_write=%b want %0d", state, mem_write, waitSt);
            end
            @(negedge clk);
            reset = 1'b1;
            mem_ready = 1'b0;
            #1;
            nCmp++;
            if ({mem_write, reg_write, instr_done} !== 3'b000 || state !== 4'(waitSt)) begin
                nFail++;
                $display("FAIL reset_mid assert: mem_write=%b reg_write=%b instr_done=%b state=%0d want 000 %0d",
                         mem_write, reg_write, instr_done, state, waitSt);
            end
            @(negedge clk);
            #1;
            nCmp++;
            if (state !== 4'd0) begin
                nFail++;
                $display("FAIL reset_mid state after edge: got %0d want 0", state);
            end
            reset = 1'b0;
            #1;
            nCmp++;
            if (dn != 0 || wr != 0 || mem_read !== 1'b1 || alu_op !== 3'b101) begin
                nFail++;
                $display("FAIL reset_mid after: instr_done=%0d reg_write=%0d mem_read=%b alu_op=%b want 0 0 1 101",
                         dn, wr, mem_read, alu_op);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        opcode = 6'd0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_back_to_back();
        test_imm();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
